// File: rtl/finn_counter_bank_pkg.sv
// Shared types and constants for the FINN RTL counter bank.
// The optional threshold comparator is enabled with FINN_COUNTER_BANK_THRESH_EN.
package finn_counter_bank_pkg;

    // Per-lane command resolved from the load/incr/decr strobes
    typedef enum logic [1:0] {
        HOLD = 2'd0,
        LOAD = 2'd1,
        INC  = 2'd2,
        DEC  = 2'd3
    } cmd_e;

    // Values for the C_SATURATE parameter
    localparam int WRAP = 0;
    localparam int SAT  = 1;

    // Load wins over arithmetic; incr and decr together cancel out
    function automatic cmd_e decode_cmd(input logic i_load, input logic i_incr, input logic i_decr);
        cmd_e v_cmd;
        if (i_load) begin
            v_cmd = LOAD;
        end else if (i_incr && !i_decr) begin
            v_cmd = INC;
        end else if (!i_incr && i_decr) begin
            v_cmd = DEC;
        end else begin
            v_cmd = HOLD;
        end
        return v_cmd;
    endfunction

endpackage

// File: rtl/finn_counter_bank_lane.sv
// One counter channel: load / step up / step down with wrap or clamp,
// sticky overflow and underflow flags, registered zero indication.
// FINN_COUNTER_BANK_THRESH_EN adds a registered count >= thresh output.
module finn_counter_bank_lane
    import finn_counter_bank_pkg::*;
#(
    parameter int                 C_WIDTH    = 8,
    parameter logic [C_WIDTH-1:0] C_INIT     = '0,
    parameter int                 C_SATURATE = WRAP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clken,
    input  logic               load,
    input  logic               incr,
    input  logic               decr,
    input  logic               clr_flags,
    input  logic [C_WIDTH-1:0] load_value,
    input  logic [C_WIDTH-1:0] step,
`ifdef FINN_COUNTER_BANK_THRESH_EN
    input  logic [C_WIDTH-1:0] thresh,
    output logic               at_thresh,
`endif
    output logic [C_WIDTH-1:0] count,
    output logic               is_zero,
    output logic               ovf,
    output logic               unf
);

    logic [C_WIDTH-1:0] r_count;
    logic               r_is_zero;
    logic               r_ovf;
    logic               r_unf;
    logic [C_WIDTH-1:0] w_count_nxt;
    logic               w_ovf_evt;
    logic               w_unf_evt;
    logic [C_WIDTH:0]   w_sum;
    logic [C_WIDTH:0]   w_diff;
    cmd_e               w_cmd;

    assign w_cmd  = decode_cmd(load, incr, decr);
    // One extra bit captures carry out of the add and borrow out of the subtract
    assign w_sum  = {1'b0, r_count} + {1'b0, step};
    assign w_diff = {1'b0, r_count} - {1'b0, step};

    // Next count and this cycle's overflow/underflow events
    always_comb begin
        w_count_nxt = r_count;
        w_ovf_evt   = 1'b0;
        w_unf_evt   = 1'b0;
        case (w_cmd)
            LOAD: begin
                w_count_nxt = load_value;
            end
            INC: begin
                w_ovf_evt = w_sum[C_WIDTH];
                if (w_sum[C_WIDTH] && (C_SATURATE == SAT)) begin
                    w_count_nxt = '1;
                end else begin
                    w_count_nxt = w_sum[C_WIDTH-1:0];
                end
            end
            DEC: begin
                w_unf_evt = w_diff[C_WIDTH];
                if (w_diff[C_WIDTH] && (C_SATURATE == SAT)) begin
                    w_count_nxt = '0;
                end else begin
                    w_count_nxt = w_diff[C_WIDTH-1:0];
                end
            end
            default: begin
                w_count_nxt = r_count;
            end
        endcase
    end

    // Count, zero flag and sticky flags; a new event beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= C_INIT;
            r_is_zero <= (C_INIT == '0);
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
        end else if (clken) begin
            r_count   <= w_count_nxt;
            r_is_zero <= (w_count_nxt == '0);
            r_ovf     <= w_ovf_evt | (r_ovf & ~clr_flags);
            r_unf     <= w_unf_evt | (r_unf & ~clr_flags);
        end else begin
            r_count   <= r_count;
            r_is_zero <= r_is_zero;
            r_ovf     <= r_ovf;
            r_unf     <= r_unf;
        end
    end

`ifdef FINN_COUNTER_BANK_THRESH_EN
    logic r_at_thresh;

    // Threshold compare of the current registered count, so it trails count by one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_at_thresh <= 1'b0;
        end else if (clken) begin
            r_at_thresh <= (r_count >= thresh);
        end else begin
            r_at_thresh <= r_at_thresh;
        end
    end

    assign at_thresh = r_at_thresh;
`endif

    assign count   = r_count;
    assign is_zero = r_is_zero;
    assign ovf     = r_ovf;
    assign unf     = r_unf;

endmodule

// File: rtl/finn_rtl_krnl_counter_bank.sv
// Bank of C_NUM_CH independent counters sharing one step magnitude.
// Buses pack channel i at [i*C_WIDTH +: C_WIDTH].
// FINN_COUNTER_BANK_THRESH_EN adds the thresh input and at_thresh output.
module finn_rtl_krnl_counter_bank
    import finn_counter_bank_pkg::*;
#(
    parameter int                 C_NUM_CH   = 2,
    parameter int                 C_WIDTH    = 8,
    parameter logic [C_WIDTH-1:0] C_INIT     = '0,
    parameter int                 C_SATURATE = WRAP
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clken,
    input  logic [C_NUM_CH-1:0]         load,
    input  logic [C_NUM_CH-1:0]         incr,
    input  logic [C_NUM_CH-1:0]         decr,
    input  logic [C_NUM_CH-1:0]         clr_flags,
    input  logic [C_NUM_CH*C_WIDTH-1:0] load_value,
    input  logic [C_WIDTH-1:0]          step,
`ifdef FINN_COUNTER_BANK_THRESH_EN
    input  logic [C_NUM_CH*C_WIDTH-1:0] thresh,
    output logic [C_NUM_CH-1:0]         at_thresh,
`endif
    output logic [C_NUM_CH*C_WIDTH-1:0] count,
    output logic [C_NUM_CH-1:0]         is_zero,
    output logic [C_NUM_CH-1:0]         ovf,
    output logic [C_NUM_CH-1:0]         unf
);

    for (genvar g = 0; g < C_NUM_CH; g++) begin : g_lane
        finn_counter_bank_lane #(
            .C_WIDTH    (C_WIDTH),
            .C_INIT     (C_INIT),
            .C_SATURATE (C_SATURATE)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .clken      (clken),
            .load       (load[g]),
            .incr       (incr[g]),
            .decr       (decr[g]),
            .clr_flags  (clr_flags[g]),
            .load_value (load_value[g*C_WIDTH +: C_WIDTH]),
            .step       (step),
`ifdef FINN_COUNTER_BANK_THRESH_EN
            .thresh     (thresh[g*C_WIDTH +: C_WIDTH]),
            .at_thresh  (at_thresh[g]),
`endif
            .count      (count[g*C_WIDTH +: C_WIDTH]),
            .is_zero    (is_zero[g]),
            .ovf        (ovf[g]),
            .unf        (unf[g])
        );
    end

endmodule

// File: tb/tb_finn_rtl_krnl_counter_bank.sv
// Scoreboard bench for finn_rtl_krnl_counter_bank: a wrap bank (init 3) and a
// saturating bank (init 0), 2 channels x 4 bits, driven with identical stimulus.
// Define FINN_COUNTER_BANK_THRESH_EN to also cover the threshold outputs.
module tb_finn_rtl_krnl_counter_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clken = 1'b0;
    logic [1:0] load = 2'b00, incr = 2'b00, decr = 2'b00, clr = 2'b00;
    logic [7:0] lv = 8'h00;
    logic [3:0] step = 4'h0;
    logic [7:0] th = 8'h00;

    logic [7:0] cnt0, cnt1;
    logic [1:0] z0, z1, o0, o1, u0, u1, a0, a1;

    always #5 clk = ~clk;

    finn_rtl_krnl_counter_bank #(.C_NUM_CH(2), .C_WIDTH(4), .C_INIT(4'd3), .C_SATURATE(0)) u_dut_wrap (
        .clk(clk), .rst(rst), .clken(clken), .load(load), .incr(incr), .decr(decr),
        .clr_flags(clr), .load_value(lv), .step(step),
`ifdef FINN_COUNTER_BANK_THRESH_EN
        .thresh(th), .at_thresh(a0),
`endif
        .count(cnt0), .is_zero(z0), .ovf(o0), .unf(u0));

    finn_rtl_krnl_counter_bank #(.C_NUM_CH(2), .C_WIDTH(4), .C_INIT(4'd0), .C_SATURATE(1)) u_dut_sat (
        .clk(clk), .rst(rst), .clken(clken), .load(load), .incr(incr), .decr(decr),
        .clr_flags(clr), .load_value(lv), .step(step),
`ifdef FINN_COUNTER_BANK_THRESH_EN
        .thresh(th), .at_thresh(a1),
`endif
        .count(cnt1), .is_zero(z1), .ovf(o1), .unf(u1));

`ifndef FINN_COUNTER_BANK_THRESH_EN
    assign a0 = 2'b00;
    assign a1 = 2'b00;
`endif

    typedef struct packed {
        logic [1:0][7:0] cnt;
        logic [1:0][1:0] z;
        logic [1:0][1:0] o;
        logic [1:0][1:0] u;
        logic [1:0][1:0] a;
    } exp_t;

    exp_t sbq[$];
    int   n_pass = 0;
    int   n_total = 0;

    // Reference state: plain integers per bank/channel
    int mcnt[2][2];
    bit movf[2][2];
    bit munf[2][2];
    bit mat[2][2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Apply one cycle of stimulus, advance the model and queue the expected outputs
    task automatic cyc(input logic r_i, input logic ce_i, input logic [1:0] ld_i,
                       input logic [1:0] inc_i, input logic [1:0] dec_i, input logic [1:0] clr_i,
                       input logic [7:0] lv_i, input logic [3:0] st_i, input logic [7:0] th_i);
        exp_t e;
        @(negedge clk);
        rst = r_i; clken = ce_i; load = ld_i; incr = inc_i; decr = dec_i;
        clr = clr_i; lv = lv_i; step = st_i; th = th_i;
        for (int d = 0; d < 2; d++) begin
            for (int ch = 0; ch < 2; ch++) begin
                int c, s, stv, lvv, thv;
                bit no, nu;
                c   = mcnt[d][ch];
                stv = int'(st_i);
                lvv = int'(lv_i[ch*4 +: 4]);
                thv = int'(th_i[ch*4 +: 4]);
                no  = 1'b0;
                nu  = 1'b0;
                if (r_i) begin
                    mcnt[d][ch] = (d == 0) ? 3 : 0;
                    movf[d][ch] = 1'b0;
                    munf[d][ch] = 1'b0;
                    mat[d][ch]  = 1'b0;
                end else if (ce_i) begin
                    mat[d][ch] = (c >= thv);
                    if (ld_i[ch]) begin
                        c = lvv;
                    end else if (inc_i[ch] && !dec_i[ch]) begin
                        s = c + stv;
                        if (s > 15) begin
                            no = 1'b1;
                            s = (d == 1) ? 15 : s - 16;
                        end
                        c = s;
                    end else if (dec_i[ch] && !inc_i[ch]) begin
                        s = c - stv;
                        if (s < 0) begin
                            nu = 1'b1;
                            s = (d == 1) ? 0 : s + 16;
                        end
                        c = s;
                    end
                    mcnt[d][ch] = c;
                    movf[d][ch] = no || (movf[d][ch] && !clr_i[ch]);
                    munf[d][ch] = nu || (munf[d][ch] && !clr_i[ch]);
                end
                e.cnt[d][ch*4 +: 4] = 4'(mcnt[d][ch]);
                e.z[d][ch] = (mcnt[d][ch] == 0);
                e.o[d][ch] = movf[d][ch];
                e.u[d][ch] = munf[d][ch];
                e.a[d][ch] = mat[d][ch];
            end
        end
        sbq.push_back(e);
    endtask

    // Wait until the outputs for the last driven command are visible
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: after every active edge, compare the DUT against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("wrap_count", {24'd0, cnt0}, {24'd0, e.cnt[0]});
                chk("wrap_zero",  {30'd0, z0}, {30'd0, e.z[0]});
                chk("wrap_ovf",   {30'd0, o0}, {30'd0, e.o[0]});
                chk("wrap_unf",   {30'd0, u0}, {30'd0, e.u[0]});
                chk("sat_count",  {24'd0, cnt1}, {24'd0, e.cnt[1]});
                chk("sat_zero",   {30'd0, z1}, {30'd0, e.z[1]});
                chk("sat_ovf",    {30'd0, o1}, {30'd0, e.o[1]});
                chk("sat_unf",    {30'd0, u1}, {30'd0, e.u[1]});
`ifdef FINN_COUNTER_BANK_THRESH_EN
                chk("wrap_at_thresh", {30'd0, a0}, {30'd0, e.a[0]});
                chk("sat_at_thresh",  {30'd0, a1}, {30'd0, e.a[1]});
`endif
            end
        end
    end

    // Stimulus: directed spec scenarios, then randomized traffic
    initial begin
        // reset state
        cyc(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 4'h0, 8'h00);
        cyc(1'b1, 1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 8'hFF, 4'h1, 8'h00);
        settle();
        chk("rst_wrap_count", {24'd0, cnt0}, 32'h33);
        chk("rst_sat_zero",   {30'd0, z1}, 32'h3);

        // wrap: 14 + 3 -> 1 with overflow
        cyc(1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 8'h0E, 4'h0, 8'h00);
        cyc(1'b0, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 8'h00, 4'h3, 8'h00);
        settle();
        chk("wrap_14p3_count", {28'd0, cnt0[3:0]}, 32'd1);
        chk("wrap_14p3_ovf",   {31'd0, o0[0]}, 32'd1);
        chk("wrap_14p3_zero",  {31'd0, z0[0]}, 32'd0);

        // saturate: 2 - 5 -> 0 with underflow
        cyc(1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 8'h02, 4'h0, 8'h00);
        cyc(1'b0, 1'b1, 2'b00, 2'b00, 2'b01, 2'b00, 8'h00, 4'h5, 8'h00);
        settle();
        chk("sat_2m5_count", {28'd0, cnt1[3:0]}, 32'd0);
        chk("sat_2m5_unf",   {31'd0, u1[0]}, 32'd1);
        chk("sat_2m5_zero",  {31'd0, z1[0]}, 32'd1);

        // independent channels, then incr&decr cancel
        cyc(1'b0, 1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 8'h55, 4'h0, 8'h00);
        cyc(1'b0, 1'b1, 2'b00, 2'b01, 2'b10, 2'b00, 8'h00, 4'h1, 8'h00);
        settle();
        chk("indep_count", {24'd0, cnt0}, 32'h46);
        cyc(1'b0, 1'b1, 2'b00, 2'b01, 2'b01, 2'b00, 8'h00, 4'h1, 8'h00);
        settle();
        chk("incdec_hold", {28'd0, cnt0[3:0]}, 32'd6);

        // overflow event beats a same-cycle clear
        cyc(1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b01, 8'h0C, 4'h0, 8'h00);
        cyc(1'b0, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 8'h00, 4'h8, 8'h00);
        cyc(1'b0, 1'b1, 2'b00, 2'b01, 2'b00, 2'b01, 8'h00, 4'hE, 8'h00);
        settle();
        chk("clr_vs_ovf_wrap", {31'd0, o0[0]}, 32'd1);
        chk("clr_vs_ovf_sat",  {31'd0, o1[0]}, 32'd1);
        cyc(1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b01, 8'h00, 4'h0, 8'h00);
        settle();
        chk("clr_alone", {31'd0, o0[0]}, 32'd0);

        // load beats incr; clken low holds
        cyc(1'b0, 1'b1, 2'b01, 2'b01, 2'b00, 2'b00, 8'h09, 4'h1, 8'h00);
        settle();
        chk("load_wins", {28'd0, cnt0[3:0]}, 32'd9);
        cyc(1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 8'h02, 4'h0, 8'h00);
        settle();
        chk("clken_hold", {28'd0, cnt0[3:0]}, 32'd9);

        // step of zero does nothing
        cyc(1'b0, 1'b1, 2'b00, 2'b11, 2'b00, 2'b11, 8'h00, 4'h0, 8'h00);
        cyc(1'b0, 1'b1, 2'b00, 2'b00, 2'b11, 2'b00, 8'h00, 4'h0, 8'h00);
        settle();
        chk("step0_count", {28'd0, cnt0[3:0]}, 32'd9);

`ifdef FINN_COUNTER_BANK_THRESH_EN
        // threshold trails count by one cycle
        cyc(1'b0, 1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 8'h66, 4'h0, 8'h88);
        cyc(1'b0, 1'b1, 2'b00, 2'b11, 2'b00, 2'b00, 8'h00, 4'h1, 8'h88);
        cyc(1'b0, 1'b1, 2'b00, 2'b11, 2'b00, 2'b00, 8'h00, 4'h1, 8'h88);
        settle();
        chk("thr_count8", {28'd0, cnt0[3:0]}, 32'd8);
        chk("thr_lag",    {31'd0, a0[0]}, 32'd0);
        cyc(1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 4'h0, 8'h88);
        settle();
        chk("thr_rise", {31'd0, a0[0]}, 32'd1);
        cyc(1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 4'h0, 8'h88);
        settle();
        chk("thr_rst_at",    {31'd0, a0[0]}, 32'd0);
        chk("thr_rst_count", {28'd0, cnt0[3:0]}, 32'd3);
`endif

        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            logic [3:0] st;
            st = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
            cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) != 0),
                2'($urandom_range(0, 7) == 0) | {1'($urandom_range(0, 7) == 0), 1'b0},
                2'($urandom), 2'($urandom),
                2'($urandom_range(0, 5) == 0) | {1'($urandom_range(0, 5) == 0), 1'b0},
                8'($urandom), st, 8'($urandom));
        end

        repeat (3) @(posedge clk);
        #3;
        chk("scoreboard_drained", sbq.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/finn_rtl_krnl_counter_bank.md
FINN_RTL_KRNL_COUNTER_BANK -- requirements
Module: finn_rtl_krnl_counter_bank

Interface
REQ-001 SHALL have parameter C_NUM_CH, default 2, number of independent counter channels (1..32).
REQ-002 SHALL have parameter C_WIDTH, default 8, bits per channel count (2..32).
REQ-003 SHALL have parameter C_INIT, default 0, per-channel reset/initial count (C_WIDTH bits).
REQ-004 SHALL have parameter C_SATURATE, default 0: 0 = modular wrap, 1 = clamp at 0 / all-ones.
REQ-005 SHALL have ports clk input 1 (clock) and rst input 1; reset rst is synchronous and active-high; clock clk.
REQ-006 SHALL have port clken input 1, global clock enable.
REQ-007 SHALL have ports load, incr, decr, clr_flags, each input C_NUM_CH, one bit per channel.
REQ-008 SHALL have port load_value input C_NUM_CH*C_WIDTH, channel i at bits [i*C_WIDTH +: C_WIDTH].
REQ-009 SHALL have port step input C_WIDTH, shared increment/decrement magnitude.
REQ-010 SHALL have port count output C_NUM_CH*C_WIDTH, same packing as load_value.
REQ-011 SHALL have ports is_zero, ovf, unf, each output C_NUM_CH.

Function
REQ-012 Per channel, SHALL apply priority on clk edge: rst > !clken (hold all state) > load > (incr XOR decr) step > hold.
REQ-013 load SHALL set count to load_value; flags unaffected.
REQ-014 incr&~decr SHALL add step; ~incr&decr SHALL subtract step; incr&decr or neither SHALL hold.
REQ-015 Arithmetic SHALL use a C_WIDTH+1-bit intermediate; carry/borrow out marks overflow/underflow.
REQ-016 Wrap mode SHALL keep result mod 2^C_WIDTH; saturate mode SHALL clamp to all-ones on overflow, 0 on underflow.
REQ-017 ovf SHALL be sticky, set on any overflowing increment in either mode; unf likewise for decrements.
REQ-018 clr_flags[i] (only while clken) SHALL clear ovf[i]/unf[i]; a same-cycle new overflow/underflow event SHALL win over clear.
REQ-019 step = 0 SHALL leave count unchanged and raise no flags.
REQ-020 count and is_zero SHALL be registered, updating together one cycle after the sampled command; is_zero SHALL equal (count == 0) at all times.
REQ-021 Channels SHALL be fully independent; simultaneous commands on all channels SHALL be honoured in one cycle.

Reset
REQ-022 On rst, every channel SHALL go to count = C_INIT, is_zero = (C_INIT == 0), ovf = 0, unf = 0, regardless of clken.
REQ-023 rst asserted mid-operation SHALL discard that cycle's commands; first command after rst deassertion takes effect next edge.

Configuration
REQ-024 Macro FINN_COUNTER_BANK_THRESH_EN, when defined, SHALL add input thresh (C_NUM_CH*C_WIDTH) and output at_thresh (C_NUM_CH).
REQ-025 With it, at_thresh[i] SHALL be registered (count[i] >= thresh[i]) updated every cycle clken is high, reset 0, lagging count by one cycle.
REQ-026 Without it, those ports and comparators SHALL not exist; all other behaviour identical.

Structure
REQ-027 Package finn_counter_bank_pkg SHALL hold the cmd enumeration (HOLD, LOAD, INC, DEC) and mode constants WRAP/SAT.
REQ-028 One sub-module finn_counter_bank_lane SHALL implement one channel; top SHALL generate C_NUM_CH lanes and pack/unpack buses.

Verification
REQ-029 W=4, wrap, count=14, step=3, incr -> count=1, ovf=1, is_zero=0.
REQ-030 W=4, saturate, count=2, step=5, decr -> count=0, unf=1, is_zero=1.
REQ-031 ch0 incr and ch1 decr same cycle, step=1, from 5/5 -> 6/4; incr&decr both on ch0 -> ch0 holds 6.
REQ-032 ovf=1 then clr_flags with a concurrent overflowing incr -> ovf stays 1; next cycle clr alone -> ovf=0.
REQ-033 load=1 with incr=1, load_value=9 -> count=9; clken=0 with load -> count unchanged.
REQ-034 THRESH_EN, thresh=8, count stepping 6,7,8 -> at_thresh rises one cycle after count reaches 8; rst -> at_thresh=0, count=C_INIT.
